// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
//
// Two-master Wishbone arbiter placed in front of the user-project address
// decoder. Master 0 is the management CPU and master 1 is the DMA engine.
// The bus is granted round-robin and the grant is held for the whole cyc
// period of the owner, so bursts and locked sequences are never split.
// Ack and read data are returned only to the granted master.
//
// Optional feature (compile-time macro WB_ARB_TIMEOUT_EN):
//   A watchdog terminates a strobe the decoder never acknowledges. It answers
//   the granted master with ack and 32'hDEAD_BEEF and pulses timeout_o. When
//   the macro is not defined there is no counter and timeout_o is tied low.
//
// Parameters
//   TIMEOUT   stalled strobe cycles before forced termination (2..1023)
//
// Ports
//   wb_clk_i               bus clock
//   wb_rst_i               synchronous, active-low reset
//   m0_cyc/stb/we/sel/adr/dat_i, m0_ack_o, m0_dat_o   CPU master port
//   m1_cyc/stb/we/sel/adr/dat_i, m1_ack_o, m1_dat_o   DMA master port
//   s_cyc/stb/we/sel/adr/dat_o                        towards the decoder
//   s_ack_i, s_dat_i                                  from the decoder
//   gnt_o                  one-hot grant: 01 = m0, 10 = m1, 00 = idle
//   timeout_o              one-cycle pulse on watchdog termination
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0]  IDLE = 2'b00;
    localparam logic [1:0]  GNT0 = 2'b01;
    localparam logic [1:0]  GNT1 = 2'b10;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic       last_r;
    logic       last_next_s;
    logic       stb_raw_s;   // granted master's strobe before watchdog forcing
    logic       tmo_s;       // watchdog fires in this cycle

    // Next-state: round-robin on a tie in IDLE, grant held while owner keeps cyc.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next_s = last_r ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next_s = GNT0;
                end else if (m1_cyc_i) begin
                    state_next_s = GNT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT0: begin
                if (m0_cyc_i) begin
                    state_next_s = GNT0;
                end else if (m1_cyc_i) begin
                    state_next_s = GNT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT1: begin
                if (m1_cyc_i) begin
                    state_next_s = GNT1;
                end else if (m0_cyc_i) begin
                    state_next_s = GNT0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Remember the master entering (or keeping) the grant; unchanged on IDLE.
    always_comb begin
        case (state_next_s)
            GNT0:    last_next_s = 1'b0;
            GNT1:    last_next_s = 1'b1;
            default: last_next_s = last_r;
        endcase
    end

    // Grant state and round-robin pointer; reset gives m0 the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_next_s;
            last_r  <= last_next_s;
        end
    end

    assign gnt_o = state_r;

    // Strobe of the granted master, used by the watchdog before forcing.
    always_comb begin
        case (state_r)
            GNT0:    stb_raw_s = m0_stb_i;
            GNT1:    stb_raw_s = m1_stb_i;
            default: stb_raw_s = 1'b0;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Compare against TIMEOUT-1 so the termination lands on the TIMEOUT-th
    // stalled cycle, counting the first stalled cycle as number one.
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

    logic [9:0] wd_cnt_r;
    logic [9:0] wd_cnt_next_s;
    logic       stall_s;

    // A genuine ack always has priority over the watchdog.
    assign stall_s = stb_raw_s & ~s_ack_i;
    assign tmo_s   = stall_s & (wd_cnt_r == TIMEOUT_LAST);

    // Watchdog count: restarts on grant change, ack, idle strobe or firing.
    always_comb begin
        if (state_next_s != state_r) begin
            wd_cnt_next_s = 10'd0;
        end else if (tmo_s) begin
            wd_cnt_next_s = 10'd0;
        end else if (stall_s) begin
            wd_cnt_next_s = wd_cnt_r + 10'd1;
        end else begin
            wd_cnt_next_s = 10'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wd_cnt_r <= 10'd0;
        end else begin
            wd_cnt_r <= wd_cnt_next_s;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    assign timeout_o = tmo_s;

    // Slave-side mux and return path; everything is zero outside the owner.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_adr_o  = 32'h0;
        s_dat_o  = 32'h0;
        m0_ack_o = 1'b0;
        m0_dat_o = 32'h0;
        m1_ack_o = 1'b0;
        m1_dat_o = 32'h0;
        case (state_r)
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~tmo_s;
                s_stb_o  = m0_stb_i & ~tmo_s;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i | tmo_s;
                if (tmo_s) begin
                    m0_dat_o = TIMEOUT_DATA;
                end else begin
                    m0_dat_o = s_dat_i;
                end
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~tmo_s;
                s_stb_o  = m1_stb_i & ~tmo_s;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i | tmo_s;
                if (tmo_s) begin
                    m1_dat_o = TIMEOUT_DATA;
                end else begin
                    m1_dat_o = s_dat_i;
                end
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2
//
// Self-checking bench for wb_arbiter2. A behavioural model tracks the current
// owner (-1 idle, 0, 1), the last-served master and the number of stalled
// cycles, and predicts every output each cycle. Directed scenarios cover reset,
// a single read, tie/handoff, burst lock, the watchdog and reset in the middle
// of a transaction; a randomized phase follows. Inputs change #1 after the
// rising edge, outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_arbiter2;

    localparam int TMO = 16;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        s_ack;
    logic [31:0] s_dat;

    logic        m0_ack, m1_ack, s_cyc, s_stb, s_we, tmo;
    logic [31:0] m0_rd, m1_rd, s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic [1:0]  gnt;

    wb_arbiter2 #(.TIMEOUT(TMO)) dut (
        .wb_clk_i (clk),       .wb_rst_i (rst_n),
        .m0_cyc_i (m_cyc[0]),  .m0_stb_i (m_stb[0]), .m0_we_i (m_we[0]),
        .m0_sel_i (m_sel[0]),  .m0_adr_i (m_adr[0]), .m0_dat_i (m_dat[0]),
        .m0_ack_o (m0_ack),    .m0_dat_o (m0_rd),
        .m1_cyc_i (m_cyc[1]),  .m1_stb_i (m_stb[1]), .m1_we_i (m_we[1]),
        .m1_sel_i (m_sel[1]),  .m1_adr_i (m_adr[1]), .m1_dat_i (m_dat[1]),
        .m1_ack_o (m1_ack),    .m1_dat_o (m1_rd),
        .s_cyc_o  (s_cyc),     .s_stb_o  (s_stb),    .s_we_o  (s_we),
        .s_sel_o  (s_sel),     .s_adr_o  (s_adr),    .s_dat_o (s_wdat),
        .s_ack_i  (s_ack),     .s_dat_i  (s_dat),
        .gnt_o    (gnt),       .timeout_o (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters and model state
    int          n_cmp, n_bad;
    int          own, last, wd;
    logic [1:0]  e_ack;
    logic        e_tmo, e_stall;
    // Slave responder state
    int          sl_cnt, sl_lat, sl_fix_lat;
    bit          sl_random;
    logic [31:0] sl_fix_dat;
    int          beats_left [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Predict all outputs from the owner and the current inputs, then compare.
    task automatic check_outputs();
        logic [1:0]  eg;
        logic        ec, es, ew;
        logic [3:0]  esel;
        logic [31:0] ea, ed;
        logic [31:0] erd [2];
        eg = 2'b00; ec = 1'b0; es = 1'b0; ew = 1'b0; esel = 4'h0; ea = 32'h0; ed = 32'h0;
        if (own >= 0) begin
            eg   = (own == 0) ? 2'b01 : 2'b10;
            ec   = m_cyc[own];
            es   = m_stb[own];
            ew   = m_we[own];
            esel = m_sel[own];
            ea   = m_adr[own];
            ed   = m_dat[own];
        end
        e_stall = es && !s_ack;
        e_tmo   = WD_ON && e_stall && (wd == TMO - 1);
        for (int x = 0; x < 2; x++) begin
            e_ack[x] = (own == x) && (s_ack || e_tmo);
            erd[x]   = (own == x) ? (e_tmo ? 32'hDEAD_BEEF : s_dat) : 32'h0;
        end
        chk("gnt",     32'(gnt),    32'(eg));
        chk("s_cyc",   32'(s_cyc),  32'(ec && !e_tmo));
        chk("s_stb",   32'(s_stb),  32'(es && !e_tmo));
        chk("s_we",    32'(s_we),   32'(ew));
        chk("s_sel",   32'(s_sel),  32'(esel));
        chk("s_adr",   s_adr,       ea);
        chk("s_dat",   s_wdat,      ed);
        chk("m0_ack",  32'(m0_ack), 32'(e_ack[0]));
        chk("m1_ack",  32'(m1_ack), 32'(e_ack[1]));
        chk("m0_dat",  m0_rd,       erd[0]);
        chk("m1_dat",  m1_rd,       erd[1]);
        chk("timeout", 32'(tmo),    32'(e_tmo));
    endtask

    // Advance the model across a rising edge using the inputs held in the cycle.
    task automatic model_update();
        int nxt;
        if (!rst_n) begin
            own = -1; last = 1; wd = 0;
        end else begin
            nxt = own;
            if (own < 0) begin
                if (m_cyc[0] && m_cyc[1]) nxt = 1 - last;
                else if (m_cyc[0])        nxt = 0;
                else if (m_cyc[1])        nxt = 1;
            end else if (!m_cyc[own]) begin
                nxt = m_cyc[1 - own] ? 1 - own : -1;
            end
            if (nxt != own)                wd = 0;
            else if (e_stall && !e_tmo)    wd = wd + 1;
            else                           wd = 0;
            if (nxt >= 0) last = nxt;
            own = nxt;
        end
    endtask

    // Decoder stand-in: acks after a latency, never for the 0x3000_0Fxx hole.
    task automatic slave_drive();
        bit          stb_now;
        logic [31:0] a;
        stb_now = (own >= 0) && m_cyc[own] && m_stb[own];
        if (!stb_now || e_ack != 2'b00) sl_cnt = 0;
        if (!stb_now) begin
            s_ack = 1'b0;
            s_dat = $urandom;
        end else begin
            if (sl_cnt == 0) sl_lat = sl_random ? int'($urandom_range(0, 2)) : sl_fix_lat;
            a      = m_adr[own];
            s_ack  = (a[31:8] != 24'h30000F) && (sl_cnt == sl_lat);
            s_dat  = sl_random ? $urandom : sl_fix_dat;
            sl_cnt = sl_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic finish_cycle();
        slave_drive();
        @(negedge clk);
        check_outputs();
    endtask

    // Hold inputs until master x is acknowledged; n = extra cycles needed.
    task automatic wait_ack(input int x, input int budget, output int n);
        n = 0;
        while (!e_ack[x]) begin
            if (n == budget) begin
                chk("ack_wait", 32'(e_ack[x]), 32'd1);
                return;
            end
            tick();
            finish_cycle();
            n++;
        end
    endtask

    task automatic set_req(input int x, input logic we, input logic [31:0] adr);
        m_cyc[x] = 1'b1; m_stb[x] = 1'b1; m_we[x] = we;
        m_sel[x] = 4'hF; m_adr[x] = adr;  m_dat[x] = $urandom;
    endtask

    task automatic drop_req(input int x);
        m_cyc[x] = 1'b0; m_stb[x] = 1'b0;
    endtask

    // Randomized master obeying the ownership rule: stb held until ack.
    task automatic drive_random_master(input int x);
        logic [31:0] r;
        r = $urandom;
        if (!m_cyc[x]) begin
            if (r[1:0] == 2'b00) begin
                set_req(x, r[2], 32'h3000_0000 | ($urandom & (WD_ON ? 32'h0000_0FFC : 32'h0000_07FC)));
                m_sel[x] = r[7:4];
                beats_left[x] = int'($urandom_range(1, 4));
            end
        end else if (e_ack[x]) begin
            beats_left[x]--;
            if (beats_left[x] == 0) begin
                drop_req(x);
            end else begin
                m_adr[x] = m_adr[x] + 32'd4;
                m_dat[x] = $urandom;
                m_stb[x] = (r[9:8] != 2'b00);
            end
        end else if (!m_stb[x]) begin
            m_stb[x] = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit reached at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, acks, tmos;
        n_cmp = 0; n_bad = 0;
        own = -1; last = 1; wd = 0;
        e_ack = 2'b00; e_tmo = 1'b0; e_stall = 1'b0;
        sl_cnt = 0; sl_lat = 0; sl_fix_lat = 1; sl_random = 1'b0; sl_fix_dat = 32'h0;
        beats_left[0] = 0; beats_left[1] = 0;
        s_ack = 1'b0; s_dat = 32'h0;
        m_we = 2'b00;
        rst_n = 1'b0;
        set_req(0, 1'b0, 32'h3000_0000);
        set_req(1, 1'b0, 32'h3000_0004);

        // Reset held with both masters requesting
        repeat (3) begin
            tick(); finish_cycle();
            chk("rst_gnt",  32'(gnt),    32'd0);
            chk("rst_scyc", 32'(s_cyc),  32'd0);
            chk("rst_ack0", 32'(m0_ack), 32'd0);
            chk("rst_ack1", 32'(m1_ack), 32'd0);
        end
        tick(); rst_n = 1'b1; finish_cycle();
        chk("rel_idle", 32'(gnt), 32'd0);

        // Tie right after reset goes to m0, then handoff without IDLE
        tick(); finish_cycle();
        chk("tie_m0_first", 32'(gnt), 32'd1);
        wait_ack(0, 20, n);
        tick(); drop_req(0); finish_cycle();
        chk("handoff_hold", 32'(gnt), 32'd1);
        tick(); finish_cycle();
        chk("handoff_m1", 32'(gnt), 32'd2);
        wait_ack(1, 20, n);
        tick(); drop_req(1); finish_cycle();
        tick(); finish_cycle();
        chk("back_idle", 32'(gnt), 32'd0);

        // Single read, slave acks two cycles after the strobe appears
        sl_fix_lat = 2; sl_fix_dat = 32'h1234_5678;
        tick(); set_req(0, 1'b0, 32'h3000_0100); finish_cycle();
        tick(); finish_cycle();
        chk("rd_stb", 32'(s_stb), 32'd1);
        chk("rd_adr", s_adr, 32'h3000_0100);
        wait_ack(0, 20, n);
        chk("rd_latency", 32'(n), 32'd2);
        chk("rd_ack",     32'(m0_ack), 32'd1);
        chk("rd_data",    m0_rd, 32'h1234_5678);
        chk("rd_m1_ack",  32'(m1_ack), 32'd0);
        chk("rd_m1_dat",  m1_rd, 32'h0);
        tick(); drop_req(0); finish_cycle();
        tick(); finish_cycle();

        // m1 write burst keeps the bus while m0 waits
        sl_fix_lat = 3;
        tick(); set_req(1, 1'b1, 32'h3800_0000); finish_cycle();
        tick(); finish_cycle();
        chk("lock_gnt1", 32'(gnt), 32'd2);
        tick(); set_req(0, 1'b0, 32'h3000_0200); finish_cycle();
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                tick(); m_adr[1] = 32'h3800_0000 + 32'(4 * b); m_dat[1] = $urandom; finish_cycle();
            end
            wait_ack(1, 20, n);
            chk("lock_hold", 32'(gnt), 32'd2);
            chk("burst_adr", s_adr, 32'h3800_0000 + 32'(4 * b));
        end
        tick(); drop_req(1); finish_cycle();
        tick(); finish_cycle();
        chk("lock_release_m0", 32'(gnt), 32'd1);
        wait_ack(0, 20, n);
        tick(); drop_req(0); finish_cycle();
        tick(); finish_cycle();

        // m1 served alone, so the following tie must go to m0
        sl_fix_lat = 0;
        tick(); set_req(1, 1'b0, 32'h3000_0300); finish_cycle();
        wait_ack(1, 20, n);
        tick(); drop_req(1); finish_cycle();
        tick(); finish_cycle();
        tick(); set_req(0, 1'b0, 32'h3000_0400); set_req(1, 1'b0, 32'h3000_0404); finish_cycle();
        tick(); finish_cycle();
        chk("tie_after_m1", 32'(gnt), 32'd1);
        wait_ack(0, 20, n);
        tick(); drop_req(0); finish_cycle();
        wait_ack(1, 20, n);
        tick(); drop_req(1); finish_cycle();
        tick(); finish_cycle();

        // Read to the unmapped hole
        tick(); set_req(1, 1'b0, 32'h3000_0F00); finish_cycle();
        tick(); finish_cycle();
`ifdef WB_ARB_TIMEOUT_EN
        wait_ack(1, 40, n);
        chk("wd_stall_cycle", 32'(n + 1), 32'(TMO));
        chk("wd_ack",     32'(m1_ack), 32'd1);
        chk("wd_data",    m1_rd, 32'hDEAD_BEEF);
        chk("wd_pulse",   32'(tmo), 32'd1);
        chk("wd_stb_off", 32'(s_stb), 32'd0);
`else
        acks = 0; tmos = 0;
        repeat (1000) begin
            tick(); finish_cycle();
            acks += int'(m1_ack);
            tmos += int'(tmo);
        end
        chk("nowd_acks",    32'(acks), 32'd0);
        chk("nowd_timeout", 32'(tmos), 32'd0);
        chk("nowd_held",    32'(gnt),  32'd2);
`endif
        tick(); drop_req(1); finish_cycle();
        tick(); finish_cycle();

        // Reset while m0 is stalled
        tick(); set_req(0, 1'b0, 32'h3000_0F04); finish_cycle();
        repeat (5) begin tick(); finish_cycle(); end
        chk("rstmid_before", 32'(gnt), 32'd1);
        tick(); rst_n = 1'b0; finish_cycle();
        tick(); finish_cycle();
        chk("rstmid_gnt",  32'(gnt),    32'd0);
        chk("rstmid_ack",  32'(m0_ack), 32'd0);
        chk("rstmid_scyc", 32'(s_cyc),  32'd0);
        tick(); rst_n = 1'b1; drop_req(0); finish_cycle();

        // Randomized traffic from both masters
        sl_random = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive_random_master(0);
            drive_random_master(1);
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
